ascii_hex_parser: RTL and testbench

Converts a stream of ASCII hex characters into binary words. It is the inverse of the nibble-to-ASCII LCD character path. It sits between a byte-wide character source (UART receiver or keypad front end) and the MIPS debug/load logic. Characters arrive over a valid/ready handshake, hex digits accumulate MSB-first into a word, and each completed word leaves over a second valid/ready handshake.

---
 rtl/ascii_hex_parser.sv | 158 +++++++++++++++
 tb/tb_ascii_hex_parser.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ascii_hex_parser.sv
// ascii_hex_parser
// ----------------
// Turns a stream of ASCII hex characters into binary words. The parser sits
// between a byte-wide character source (UART receiver or keypad front end)
// and the MIPS debug/load logic.
//
// Hex digits accumulate MSB-first. A word is finished when NDIG digits have
// arrived, or earlier when a terminator (CR, LF or space) follows at least
// one digit. A finished word leaves over a valid/ready handshake. An illegal
// character throws away the partial word and raises a one-cycle err pulse.
//
// Ports:
//   clk        in   system clock; all state updates on the rising edge
//   rst_n      in   asynchronous active-low reset
//   char_in    in   [7:0]          ASCII character from the source
//   char_valid in   char_in holds a valid character
//   char_ready out  parser can accept a character this cycle
//   word_out   out  [WORD_W-1:0]   assembled word, right-aligned, zero-extended
//   word_valid out  word_out valid; held until accepted
//   word_ready in   consumer accepts word_out
//   digit_cnt  out  [CW-1:0]       digits accumulated in the current word
//   err        out  one-cycle pulse after an illegal character is accepted
module ascii_hex_parser #(
    parameter int WORD_W = 32,
    parameter int NDIG   = WORD_W / 4,
    localparam int CW    = $clog2(NDIG + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        char_in,
    input  logic              char_valid,
    output logic              char_ready,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [CW-1:0]     digit_cnt,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              err_q, err_d;

    logic              charXfer;
    logic              isDigit;
    logic              isTerm;
    logic [3:0]        nib;
    logic [CW-1:0]     cntInc;
    logic [WORD_W-1:0] accShift;

    // Character classification. Letters A-F/a-f have low nibbles 1..6,
    // so adding 9 gives the values 10..15 without needing a subtractor.
    always_comb begin
        isDigit = 1'b0;
        isTerm  = 1'b0;
        nib     = 4'd0;
        if (char_in >= 8'h30 && char_in <= 8'h39) begin
            isDigit = 1'b1;
            nib     = char_in[3:0];
        end else if ((char_in >= 8'h41 && char_in <= 8'h46) ||
                     (char_in >= 8'h61 && char_in <= 8'h66)) begin
            isDigit = 1'b1;
            nib     = char_in[3:0] + 4'd9;
        end else if (char_in == 8'h0D || char_in == 8'h0A || char_in == 8'h20) begin
            isTerm  = 1'b1;
        end
    end

    // char_ready depends on state only, so the source never sees a
    // combinational path from its own valid back to ready.
    assign char_ready = (state_q != EMIT);
    assign charXfer   = char_valid && char_ready;

    // The shift form works for every legal WORD_W, including WORD_W == 4
    // where a part-select of the lower bits would be empty.
    assign accShift = (acc_q << 4) | WORD_W'(nib);
    assign cntInc   = cnt_q + CW'(1);

    // Next-state logic for the character/word handshakes.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (charXfer) begin
                    if (isDigit) begin
                        acc_d   = accShift;
                        cnt_d   = CW'(1);
                        state_d = (NDIG == 1) ? EMIT : ACCUM;
                    end else if (!isTerm) begin
                        err_d   = 1'b1;
                    end
                end
            end
            ACCUM: begin
                if (charXfer) begin
                    if (isDigit) begin
                        acc_d = accShift;
                        cnt_d = cntInc;
                        if (cntInc == CW'(NDIG)) begin
                            state_d = EMIT;
                        end
                    end else if (isTerm) begin
                        state_d = EMIT;
                    end else begin
                        err_d   = 1'b1;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            EMIT: begin
                if (word_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                acc_d   = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // The accumulator is only shown while a word is being offered, so the
    // consumer never sees a half-built value on word_out.
    assign word_valid = (state_q == EMIT);
    assign word_out   = word_valid ? acc_q : '0;
    assign digit_cnt  = cnt_q;
    assign err        = err_q;

endmodule

// File: tb/tb_ascii_hex_parser.sv
// Testbench for ascii_hex_parser (WORD_W = 32, NDIG = 8).
module tb_ascii_hex_parser;

    localparam int WORD_W = 32;
    localparam int NDIG   = 8;
    localparam int CW     = $clog2(NDIG + 1);

    logic              clk;
    logic              rst_n;
    logic [7:0]        char_in;
    logic              char_valid;
    logic              char_ready;
    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic              word_ready;
    logic [CW-1:0]     digit_cnt;
    logic              err;

    ascii_hex_parser #(.WORD_W(WORD_W), .NDIG(NDIG)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .digit_cnt  (digit_cnt),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass   = 0;
    int errSeen = 0;
    logic [31:0] gotWords[$];
    logic [31:0] expWords[$];

    // Behavioural model state: value as an integer built by *16, digit count,
    // whether a word is being offered, and the expected err pulse.
    logic [31:0] mVal;
    int          mCnt;
    bit          mEmit;
    bit          mErr;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        nChecks++;
        if (actual === expected) nPass++;
        else $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    endtask

    // Returns 0..15 for a hex digit, -2 for a terminator, -1 for illegal.
    function automatic int classify(input logic [7:0] c);
        if (c >= "0" && c <= "9") return int'(c) - int'("0");
        if (c >= "A" && c <= "F") return int'(c) - int'("A") + 10;
        if (c >= "a" && c <= "f") return int'(c) - int'("a") + 10;
        if (c == 8'h0D || c == 8'h0A || c == 8'h20) return -2;
        return -1;
    endfunction

    // Model update on each clock edge, cleared asynchronously by reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mVal = 0; mCnt = 0; mEmit = 0; mErr = 0;
        end else begin
            int k;
            mErr = 0;
            if (mEmit) begin
                if (word_ready) begin
                    mEmit = 0; mVal = 0; mCnt = 0;
                end
            end else if (char_valid) begin
                k = classify(char_in);
                if (k >= 0) begin
                    mVal = mVal * 16 + k;
                    mCnt = mCnt + 1;
                    if (mCnt == NDIG) mEmit = 1;
                end else if (k == -2) begin
                    if (mCnt > 0) mEmit = 1;
                end else begin
                    mErr = 1; mVal = 0; mCnt = 0;
                end
            end
        end
    end

    // Per-cycle comparison against the model, well after inputs settle.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            checkOutput("char_ready", 64'(char_ready), 64'(!mEmit));
            checkOutput("word_valid", 64'(word_valid), 64'(mEmit));
            checkOutput("word_out",   64'(word_out),   mEmit ? 64'(mVal) : 64'd0);
            checkOutput("digit_cnt",  64'(digit_cnt),  64'(mCnt));
            checkOutput("err",        64'(err),        64'(mErr));
            if (err) errSeen++;
            if (rst_n && word_valid && word_ready) gotWords.push_back(word_out);
        end
    end

    // Sends one character; gap idle cycles first. Returns at the negedge
    // after the transfer edge, with char_valid still high.
    task automatic applyStimulus(input logic [7:0] c, input int gap);
        int n;
        if (gap > 0) begin
            char_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        char_in    = c;
        char_valid = 1'b1;
        n = 0;
        while (!char_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!char_ready) begin
            $display("[TB] FAIL char_ready timeout: got 0, required 1");
            nChecks++;
        end
        @(negedge clk);
    endtask

    task automatic sendString(input string s, input int maxGap);
        for (int i = 0; i < s.len(); i++) begin
            applyStimulus(s[i], (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0);
        end
        char_valid = 1'b0;
    endtask

    task automatic checkWords(input string name);
        repeat (3) @(negedge clk);
        checkOutput({name, " count"}, 64'(gotWords.size()), 64'(expWords.size()));
        for (int i = 0; i < expWords.size() && i < gotWords.size(); i++) begin
            checkOutput({name, " word"}, 64'(gotWords[i]), 64'(expWords[i]));
        end
        gotWords.delete();
        expWords.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        char_in    = 8'h00;
        char_valid = 1'b0;
        word_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset word_valid", 64'(word_valid), 64'd0);
        checkOutput("reset char_ready", 64'(char_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Full 8-digit word, mixed case, back to back.
        $display("[TB] test 1: 1A2b3C4d");
        sendString("1A2b3C4d", 0);
        #1;
        checkOutput("t1 digit_cnt in EMIT", 64'(digit_cnt), 64'd8);
        checkOutput("t1 word_out in EMIT",  64'(word_out),  64'h1A2B3C4D);
        expWords.push_back(32'h1A2B3C4D);
        checkWords("t1");

        // Terminated partial word, then a lone CR that must do nothing.
        $display("[TB] test 2: FF CR, CR");
        sendString("FF\r", 0);
        sendString("\r", 0);
        expWords.push_back(32'h000000FF);
        checkWords("t2");

        // Back-pressure: consumer stalls for 5 cycles.
        $display("[TB] test 3: backpressure");
        word_ready = 1'b0;
        sendString("12345678", 0);
        repeat (5) @(negedge clk);
        #1;
        checkOutput("t3 word_out held",   64'(word_out),   64'h12345678);
        checkOutput("t3 char_ready held", 64'(char_ready), 64'd0);
        word_ready = 1'b1;
        @(negedge clk);
        expWords.push_back(32'h12345678);
        checkWords("t3");

        // Illegal character mid-word discards the partial value.
        $display("[TB] test 4: 12G4 CR then 0000000A");
        sendString("12G4\r", 0);
        sendString("0000000A", 0);
        expWords.push_back(32'h00000004);
        expWords.push_back(32'h0000000A);
        checkWords("t4");
        checkOutput("t4 err pulses", 64'(errSeen), 64'd1);

        // Random gaps between characters, space as terminator.
        $display("[TB] test 5: dead BEEF0000 with gaps");
        sendString("dead BEEF0000", 3);
        expWords.push_back(32'h0000DEAD);
        expWords.push_back(32'hBEEF0000);
        checkWords("t5");

        // Reset in the middle of a word.
        $display("[TB] test 6: reset mid-word");
        sendString("ABC", 0);
        rst_n = 1'b0;
        #1;
        checkOutput("t6 rst digit_cnt",  64'(digit_cnt),  64'd0);
        checkOutput("t6 rst word_valid", 64'(word_valid), 64'd0);
        checkOutput("t6 rst word_out",   64'(word_out),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sendString("7\n", 0);
        expWords.push_back(32'h00000007);
        checkWords("t6");
        checkOutput("final err pulses", 64'(errSeen), 64'd1);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
